// File: rtl/counter_wrap_monitor.sv
// Watches an up/down counter's q, classifies each transition and counts wraps.
// Optional qbar consistency check is enabled by defining QBAR_CHECK_EN.
module counter_wrap_monitor #(
  parameter int CW = 3,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] q_in,
  input  logic [CW-1:0] qbar_in,
  input  logic          clr,
  output logic          dir_valid,
  output logic          dir_up,
  output logic          wrap_pulse,
  output logic [EW-1:0] ovf_cnt,
  output logic [EW-1:0] unf_cnt,
  output logic          err_flag
);

  localparam logic [CW-1:0] Q_MAX   = '1;
  localparam logic [CW-1:0] Q_ONE   = CW'(1);
  localparam logic [EW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN,
    STEP_JUMP
  } step_e;

  logic [CW-1:0] prev_q;
  logic          prev_valid;
  logic [CW-1:0] delta;
  step_e         step;
  logic          is_ovf;
  logic          is_unf;
  logic          qbar_err;
  logic [EW-1:0] ovf_inc;
  logic [EW-1:0] unf_inc;

  // With CW=1 a delta of 1 is both +1 and -1; prev_q breaks the tie.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    step  = STEP_JUMP;
    delta = q_in - prev_q;
    if (delta == '0)
      step = STEP_HOLD;
    else if (delta == Q_ONE && !(CW == 1 && prev_q == Q_MAX))
      step = STEP_UP;
    else if (delta == Q_MAX)
      step = STEP_DOWN;
  end

  assign is_ovf  = (step == STEP_UP)   && (prev_q == Q_MAX) && (q_in == '0);
  assign is_unf  = (step == STEP_DOWN) && (prev_q == '0)    && (q_in == Q_MAX);
  assign ovf_inc = (ovf_cnt == CNT_MAX) ? ovf_cnt : ovf_cnt + EW'(1);
  assign unf_inc = (unf_cnt == CNT_MAX) ? unf_cnt : unf_cnt + EW'(1);

`ifdef QBAR_CHECK_EN
  assign qbar_err = (qbar_in != ~q_in);
`else
  logic unused_qbar;
  assign unused_qbar = ^qbar_in;
  assign qbar_err    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments; the later clr
  // assignments intentionally override the event updates on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      prev_valid <= 1'b0;
      dir_valid  <= 1'b0;
      dir_up     <= 1'b0;
      wrap_pulse <= 1'b0;
      ovf_cnt    <= '0;
      unf_cnt    <= '0;
      err_flag   <= 1'b0;
    end else begin
      prev_q     <= q_in;
      prev_valid <= 1'b1;
      wrap_pulse <= 1'b0;

      if (prev_valid) begin
        unique case (step)
          STEP_UP: begin
            dir_up    <= 1'b1;
            dir_valid <= 1'b1;
            if (is_ovf) begin
              wrap_pulse <= 1'b1;
              ovf_cnt    <= ovf_inc;
            end
          end
          STEP_DOWN: begin
            dir_up    <= 1'b0;
            dir_valid <= 1'b1;
            if (is_unf) begin
              wrap_pulse <= 1'b1;
              unf_cnt    <= unf_inc;
            end
          end
          STEP_JUMP: err_flag <= 1'b1;
          STEP_HOLD: ;
        endcase
        if (qbar_err)
          err_flag <= 1'b1;
      end

      if (clr) begin
        ovf_cnt  <= '0;
        unf_cnt  <= '0;
        err_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Randomised and directed bench for counter_wrap_monitor against an arithmetic reference model.
module tb_counter_wrap_monitor;

  localparam int CW  = 3;
  localparam int EW  = 8;
  localparam int M   = 1 << CW;
  localparam int SAT = (1 << EW) - 1;

  typedef logic [2*EW+3:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [CW-1:0] q_in = '0;
  logic [CW-1:0] qbar_in = '1;
  logic          dir_valid, dir_up, wrap_pulse, err_flag;
  logic [EW-1:0] ovf_cnt, unf_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state (plain integers)
  int m_prev = 0, m_pv = 0, m_dv = 0, m_up = 0, m_wrap = 0, m_ovf = 0, m_unf = 0, m_err = 0;

  counter_wrap_monitor #(.CW(CW), .EW(EW)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .qbar_in(qbar_in), .clr(clr),
    .dir_valid(dir_valid), .dir_up(dir_up), .wrap_pulse(wrap_pulse),
    .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(input int q, input int qb, input bit c, input bit r);
    int d;
    if (r) begin
      m_prev = 0; m_pv = 0; m_dv = 0; m_up = 0; m_wrap = 0; m_ovf = 0; m_unf = 0; m_err = 0;
      return;
    end
    m_wrap = 0;
    if (m_pv == 0) begin
      m_pv = 1;
    end else begin
      d = ((q - m_prev) % M + M) % M;
      if (d == 0) begin
      end else if (d == 1 && !(M == 2 && m_prev == 1)) begin
        m_up = 1; m_dv = 1;
        if (m_prev == M - 1 && q == 0) begin
          m_wrap = 1;
          if (m_ovf < SAT) m_ovf++;
        end
      end else if (d == M - 1) begin
        m_up = 0; m_dv = 1;
        if (m_prev == 0 && q == M - 1) begin
          m_wrap = 1;
          if (m_unf < SAT) m_unf++;
        end
      end else begin
        m_err = 1;
      end
`ifdef QBAR_CHECK_EN
      if (qb != (M - 1 - q)) m_err = 1;
`endif
    end
    m_prev = q;
    if (c) begin
      m_ovf = 0; m_unf = 0; m_err = 0;
    end
  endfunction

  function automatic vec_t expected_vec();
    return {m_dv[0], m_up[0], m_wrap[0], EW'(m_ovf), EW'(m_unf), m_err[0]};
  endfunction

  function automatic vec_t observed_vec();
    return {dir_valid, dir_up, wrap_pulse, ovf_cnt, unf_cnt, err_flag};
  endfunction

  // Drives one clock of stimulus, advances the model, and returns #1 after the edge.
  task automatic drive(input int q, input bit qbar_bad, input bit c, input bit r);
    int qb;
    qb      = qbar_bad ? q : (M - 1 - q);
    q_in    = CW'(q);
    qbar_in = CW'(qb);
    clr     = c;
    rst     = r;
    @(posedge clk);
    model_edge(q, qb, c, r);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (observed_vec() !== vec_t'(0)) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", observed_vec(), vec_t'(0));
    end
  endtask

  task automatic test_count_up();
    int seq [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive(seq[i], 1'b0, 1'b0, 1'b0);
      vectors++;
      if (observed_vec() !== expected_vec()) begin
        miscompares++;
        $display("FAIL count_up[%0d]: got %h expected %h", i, observed_vec(), expected_vec());
      end
      if (wrap_pulse === 1'b1) begin
        pulses++;
        vectors++;
        if (i != 8) begin
          miscompares++;
          $display("FAIL count_up_pulse_pos: got index %0d expected 8", i);
        end
      end
    end
    vectors++;
    if (pulses != 1 || ovf_cnt !== EW'(1) || unf_cnt !== '0 || dir_up !== 1'b1 || dir_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL count_up_final: got pulses=%0d ovf=%0d unf=%0d up=%b valid=%b expected 1 1 0 1 1",
               pulses, ovf_cnt, unf_cnt, dir_up, dir_valid);
    end
  endtask

  task automatic test_count_down();
    int seq [13] = '{1, 0, 7, 6, 5, 4, 3, 2, 1, 0, 7, 6, 5};
    for (int i = 0; i < 13; i++) begin
      drive(seq[i], 1'b0, 1'b0, 1'b0);
      vectors++;
      if (observed_vec() !== expected_vec()) begin
        miscompares++;
        $display("FAIL count_down[%0d]: got %h expected %h", i, observed_vec(), expected_vec());
      end
    end
    vectors++;
    if (unf_cnt !== EW'(2) || ovf_cnt !== EW'(1) || dir_up !== 1'b0 || err_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL count_down_final: got unf=%0d ovf=%0d up=%b err=%b expected 2 1 0 0",
               unf_cnt, ovf_cnt, dir_up, err_flag);
    end
  endtask

  task automatic test_jump();
    drive(4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(3, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err_flag !== 1'b0 || dir_up !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_hold: got err=%b up=%b expected 0 0", err_flag, dir_up);
    end
    drive(6, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err_flag !== 1'b1 || dir_up !== 1'b0 || wrap_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_set: got err=%b up=%b wrap=%b expected 1 0 0", err_flag, dir_up, wrap_pulse);
    end
    drive(7, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err_flag !== 1'b1 || dir_up !== 1'b1 || observed_vec() !== expected_vec()) begin
      miscompares++;
      $display("FAIL jump_sticky: got err=%b up=%b expected 1 1", err_flag, dir_up);
    end
  endtask

  task automatic test_clr_wrap();
    drive(0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (ovf_cnt !== '0 || err_flag !== 1'b0 || wrap_pulse !== 1'b1 || unf_cnt !== '0 || dir_up !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_wrap: got ovf=%0d err=%b wrap=%b unf=%0d up=%b expected 0 0 1 0 1",
               ovf_cnt, err_flag, wrap_pulse, unf_cnt, dir_up);
    end
  endtask

  task automatic test_saturation();
    for (int w = 0; w < SAT + 3; w++) begin
      for (int v = 1; v <= M; v++) begin
        drive(v % M, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (observed_vec() !== expected_vec()) begin
          miscompares++;
          $display("FAIL saturation[%0d,%0d]: got %h expected %h", w, v, observed_vec(), expected_vec());
        end
      end
    end
    vectors++;
    if (ovf_cnt !== EW'(SAT) || wrap_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL saturation_hold: got ovf=%0d wrap=%b expected %0d 1", ovf_cnt, wrap_pulse, SAT);
    end
    drive(1, 1'b0, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0);
    drive(3, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (observed_vec() !== vec_t'(0)) begin
      miscompares++;
      $display("FAIL mid_reset: got %h expected %h", observed_vec(), vec_t'(0));
    end
    drive(6, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err_flag !== 1'b0 || wrap_pulse !== 1'b0 || dir_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_capture: got err=%b wrap=%b valid=%b expected 0 0 0",
               err_flag, wrap_pulse, dir_valid);
    end
    drive(7, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (dir_up !== 1'b1 || dir_valid !== 1'b1 || err_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_step: got up=%b valid=%b err=%b expected 1 1 0", dir_up, dir_valid, err_flag);
    end
  endtask

  task automatic test_qbar();
    bit exp_err;
`ifdef QBAR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    drive(7, 1'b0, 1'b1, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL qbar_before: got err=%b expected 0", err_flag);
    end
    drive(2, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (err_flag !== exp_err) begin
      miscompares++;
      $display("FAIL qbar_edge: got err=%b expected %b", err_flag, exp_err);
    end
    drive(3, 1'b0, 1'b0, 1'b0);
    drive(4, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err_flag !== exp_err || dir_up !== 1'b1) begin
      miscompares++;
      $display("FAIL qbar_sticky: got err=%b up=%b expected %b 1", err_flag, dir_up, exp_err);
    end
  endtask

  task automatic test_random();
    int q, sel;
    bit c, bad, r;
    q = m_prev;
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 40)      q = (q + 1) % M;
      else if (sel < 70) q = (q + M - 1) % M;
      else if (sel >= 85) q = $urandom_range(0, M - 1);
      c   = ($urandom_range(0, 31) == 0);
      bad = ($urandom_range(0, 49) == 0);
      r   = ($urandom_range(0, 199) == 0);
      drive(q, bad, c, r);
      vectors++;
      if (observed_vec() !== expected_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", i, observed_vec(), expected_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_jump();
    test_clr_wrap();
    test_saturation();
    test_qbar();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
